// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-direction traffic light controller.
// Every clk it samples both lamp buses and decodes each into a phase. It then checks
// lamp encoding, cross-direction safety, phase order and (optionally) dwell times.
// Each violation cycle gives a one-cycle pulse and bumps a saturating count. The first
// violation code is held until cleared. Armed NS red->green transitions are counted.
//
// Optional feature: define TLM_DWELL_CHECK_EN to enable the dwell checks (codes 4/5).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   ns_light     NS lamps {red,yellow,green}
//   ew_light     EW lamps {red,yellow,green}
//   err_clr      synchronous clear of err_sticky/err_code/err_count
//   err_pulse    one-cycle flag for a cycle containing any violation
//   err_sticky   set on the first violation, held until err_clr
//   err_code     first violation code since clear (0 = none)
//   err_count    violation-cycle count, saturating
//   cycle_count  completed NS red->green transitions, wrapping
//   ns_phase     decoded NS phase (0=R 1=Y 2=G 3=INVALID)
//   ew_phase     decoded EW phase
module traffic_light_monitor #(
  parameter int unsigned GREEN_MIN   = 5,
  parameter int unsigned GREEN_MAX   = 10,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ns_light,
  input  logic [2:0]       ew_light,
  input  logic             err_clr,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [2:0]       err_code,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       ns_phase,
  output logic [1:0]       ew_phase
);

  typedef enum logic [1:0] {
    PH_R   = 2'd0,
    PH_Y   = 2'd1,
    PH_G   = 2'd2,
    PH_INV = 2'd3
  } phase_e;

  localparam int unsigned NDIR = 2;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_MIN_C  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] YELLOW_C     = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] GREEN_LONG_C = CNT_W'(GREEN_MAX + 1);
  localparam logic [CNT_W-1:0] YEL_LONG_C   = CNT_W'(YELLOW_TIME + 1);

  // Dwell checks fold away to constant zero when the feature is not built in.
`ifdef TLM_DWELL_CHECK_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  // Per-direction state: index 0 = NS, index 1 = EW
  phase_e           phase_q [NDIR];
  phase_e           phase_d [NDIR];
  logic [CNT_W-1:0] cnt_q   [NDIR];
  logic [CNT_W-1:0] cnt_d   [NDIR];
  logic [NDIR-1:0]  armed_q, armed_d;

  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic [2:0]       lights [NDIR];
  phase_e           samp   [NDIR];
  logic [NDIR-1:0]  dir_valid, dir_red;
  logic [5:1]       flags;
  logic [2:0]       new_code;
  logic             any_err;
  logic             ns_r2g;

  // One-hot lamp decode; anything else is an encoding violation
  function automatic phase_e decode(input logic [2:0] l);
    phase_e p;
    case (l)
      3'b100:  p = PH_R;
      3'b010:  p = PH_Y;
      3'b001:  p = PH_G;
      default: p = PH_INV;
    endcase
    return p;
  endfunction

  // Per-direction phase tracking and violation detection
  always_comb begin
    flags     = '0;
    ns_r2g    = 1'b0;
    dir_valid = '0;
    dir_red   = '0;
    armed_d   = armed_q;
    lights[0] = ns_light;
    lights[1] = ew_light;
    for (int i = 0; i < NDIR; i++) begin
      samp[i]    = decode(lights[i]);
      phase_d[i] = phase_q[i];
      cnt_d[i]   = cnt_q[i];
      if (samp[i] == PH_INV) begin
        flags[1]   = 1'b1;
        phase_d[i] = PH_INV;
        cnt_d[i]   = '0;
        armed_d[i] = 1'b0;
      end else begin
        dir_valid[i] = 1'b1;
        dir_red[i]   = (samp[i] == PH_R);
        phase_d[i]   = samp[i];
        armed_d[i]   = 1'b1;
        if (samp[i] == phase_q[i]) begin
          cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
        end else begin
          cnt_d[i] = CNT_ONE;
        end
        // The arming sample is never checked against the previous phase
        if (armed_q[i]) begin
          if (samp[i] != phase_q[i]) begin
            if (!((phase_q[i] == PH_G && samp[i] == PH_Y) ||
                  (phase_q[i] == PH_Y && samp[i] == PH_R) ||
                  (phase_q[i] == PH_R && samp[i] == PH_G))) begin
              flags[3] = 1'b1;
            end
            if (DWELL_EN && phase_q[i] == PH_G && samp[i] == PH_Y &&
                cnt_q[i] < GREEN_MIN_C) begin
              flags[4] = 1'b1;
            end
            if (DWELL_EN && phase_q[i] == PH_Y && samp[i] == PH_R &&
                cnt_q[i] < YELLOW_C) begin
              flags[4] = 1'b1;
            end
            if (i == 0 && phase_q[i] == PH_R && samp[i] == PH_G) begin
              ns_r2g = 1'b1;
            end
          end else begin
            // Equality on the new count fires only on the crossing cycle
            if (DWELL_EN && samp[i] == PH_G && cnt_d[i] == GREEN_LONG_C) begin
              flags[5] = 1'b1;
            end
            if (DWELL_EN && samp[i] == PH_Y && cnt_d[i] == YEL_LONG_C) begin
              flags[5] = 1'b1;
            end
          end
        end
      end
    end
    if (dir_valid[0] && dir_valid[1] && !dir_red[0] && !dir_red[1]) begin
      flags[2] = 1'b1;
    end
  end

  // Lowest code wins when several violations share a cycle
  always_comb begin
    new_code = 3'd0;
    if (flags[5]) new_code = 3'd5;
    if (flags[4]) new_code = 3'd4;
    if (flags[3]) new_code = 3'd3;
    if (flags[2]) new_code = 3'd2;
    if (flags[1]) new_code = 3'd1;
    any_err = |flags;
  end

  // Error reporting and cycle counting; a violation overrides a same-cycle clear
  always_comb begin
    err_pulse_d   = any_err;
    err_sticky_d  = err_sticky_q;
    err_code_d    = err_code_q;
    err_count_d   = err_count_q;
    cycle_count_d = cycle_count_q + (ns_r2g ? CNT_ONE : '0);
    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_code_d   = 3'd0;
      err_count_d  = 8'd0;
    end
    if (any_err) begin
      if (!err_sticky_d) begin
        err_code_d = new_code;
      end
      err_sticky_d = 1'b1;
      if (err_count_d != 8'hFF) begin
        err_count_d = err_count_d + 8'd1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NDIR; i++) begin
        phase_q[i] <= PH_R;
        cnt_q[i]   <= '0;
      end
      armed_q       <= '0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_code_q    <= 3'd0;
      err_count_q   <= 8'd0;
      cycle_count_q <= '0;
    end else begin
      for (int i = 0; i < NDIR; i++) begin
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      armed_q       <= armed_d;
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      err_code_q    <= err_code_d;
      err_count_q   <= err_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign err_code    = err_code_q;
  assign err_count   = err_count_q;
  assign cycle_count = cycle_count_q;
  assign ns_phase    = phase_q[0];
  assign ew_phase    = phase_q[1];

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios followed by
// randomized controller traffic with injected glitches, compared every cycle
// against a behavioural model of the checking rules.
module tb_traffic_light_monitor;

  localparam int GMIN = 5;
  localparam int GMAX = 10;
  localparam int YT   = 2;
  localparam int CMAX = 255;
  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;
`ifdef TLM_DWELL_CHECK_EN
  localparam bit DW = 1'b1;
`else
  localparam bit DW = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] ns_light, ew_light;
  logic       err_clr;
  logic       err_pulse, err_sticky;
  logic [2:0] err_code;
  logic [7:0] err_count;
  logic [7:0] cycle_count;
  logic [1:0] ns_phase, ew_phase;

  traffic_light_monitor #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ns_light(ns_light), .ew_light(ew_light),
    .err_clr(err_clr), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_code(err_code), .err_count(err_count), .cycle_count(cycle_count),
    .ns_phase(ns_phase), .ew_phase(ew_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: phase as 0=R 1=Y 2=G 3=invalid; run = cycles spent in phase
  int m_ph [2];
  int m_run [2];
  bit m_arm [2];
  int m_pulse, m_sticky, m_code, m_count, m_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int to_phase(input logic [2:0] l);
    if (l == LR) return 0;
    if (l == LY) return 1;
    if (l == LG) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = 0; m_run[d] = 0; m_arm[d] = 1'b0;
    end
    m_pulse = 0; m_sticky = 0; m_code = 0; m_count = 0; m_cyc = 0;
  endtask

  task automatic model_update(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
    int ph [2];
    int worst;
    worst = 0;
    ph[0] = to_phase(ns);
    ph[1] = to_phase(ew);
    // Both lit, neither red
    if (ph[0] != 3 && ph[1] != 3 && ph[0] != 0 && ph[1] != 0) worst = 2;
    for (int d = 0; d < 2; d++) begin
      if (ph[d] == 3) begin
        worst = 1;
        m_ph[d] = 3; m_run[d] = 0; m_arm[d] = 1'b0;
      end else begin
        if (m_arm[d]) begin
          if (ph[d] != m_ph[d]) begin
            // Legal successor in the R->G->Y->R ring: G(2)->Y(1)->R(0)->G(2)
            if (ph[d] != (m_ph[d] + 2) % 3 && (worst == 0 || worst > 3)) worst = 3;
            if (DW && m_ph[d] == 2 && ph[d] == 1 && m_run[d] < GMIN && (worst == 0 || worst > 4)) worst = 4;
            if (DW && m_ph[d] == 1 && ph[d] == 0 && m_run[d] < YT && (worst == 0 || worst > 4)) worst = 4;
            if (d == 0 && m_ph[d] == 0 && ph[d] == 2) m_cyc = (m_cyc + 1) % (CMAX + 1);
          end else begin
            // This sample is the (limit+1)-th cycle in the phase
            if (DW && ph[d] == 2 && m_run[d] == GMAX && worst == 0) worst = 5;
            if (DW && ph[d] == 1 && m_run[d] == YT && worst == 0) worst = 5;
          end
        end
        m_run[d] = (ph[d] == m_ph[d]) ? ((m_run[d] < CMAX) ? m_run[d] + 1 : CMAX) : 1;
        m_ph[d]  = ph[d];
        m_arm[d] = 1'b1;
      end
    end
    m_pulse = (worst != 0) ? 1 : 0;
    if (clr) begin
      m_sticky = 0; m_code = 0; m_count = 0;
    end
    if (worst != 0) begin
      if (m_sticky == 0) m_code = worst;
      m_sticky = 1;
      if (m_count < 255) m_count++;
    end
  endtask

  task automatic check_all();
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("err_count", 32'(err_count), 32'(m_count));
    chk("cycle_count", 32'(cycle_count), 32'(m_cyc));
    chk("ns_phase", 32'(ns_phase), 32'(m_ph[0]));
    chk("ew_phase", 32'(ew_phase), 32'(m_ph[1]));
  endtask

  // Drive one sample, clock it in, advance the model, check 1 time unit later
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
    ns_light = ns;
    ew_light = ew;
    err_clr  = clr;
    @(posedge clk);
    if (!rst) model_reset();
    else model_update(ns, ew, clr);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [2:0] ns, input logic [2:0] ew, input int n);
    for (int k = 0; k < n; k++) step(ns, ew, 1'b0);
  endtask

  // Random step with occasional glitches, forced conflicts and clears
  task automatic rstep(input logic [2:0] ns, input logic [2:0] ew);
    logic [2:0] a, b;
    int r;
    a = ns;
    b = ew;
    r = int'($urandom_range(0, 39));
    if (r == 0) a = 3'($urandom_range(0, 7));
    if (r == 1) b = 3'($urandom_range(0, 7));
    if (r == 2) b = LG;
    if (r == 3) a = LR;
    step(a, b, ($urandom_range(0, 24) == 0));
  endtask

  initial begin
    int gd, yd;
    rst      = 1'b0;
    ns_light = LR;
    ew_light = LR;
    err_clr  = 1'b0;

    // Reset state
    hold(LR, LR, 3);
    chk("reset_code", 32'(err_code), 32'd0);

    // Legal traffic: first NS green is the arming sample and is not counted
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      hold(LG, LR, 5);
      hold(LY, LR, 2);
      hold(LR, LG, 5);
      hold(LR, LY, 2);
    end
    chk("legal_cycle_count", 32'(cycle_count), 32'd3);
    chk("legal_code", 32'(err_code), 32'd0);
    chk("legal_sticky", 32'(err_sticky), 32'd0);

    // Illegal encoding, then re-arm without a transition error
    step(3'b011, LR, 1'b0);
    chk("enc_code", 32'(err_code), 32'd1);
    chk("enc_phase", 32'(ns_phase), 32'd3);
    chk("enc_pulse", 32'(err_pulse), 32'd1);
    step(LG, LR, 1'b0);
    chk("rearm_pulse", 32'(err_pulse), 32'd0);

    // Conflict, then encoding error beats it on a cleared cycle
    hold(LG, LR, 3);
    step(LG, LR, 1'b1);
    step(LG, LG, 1'b0);
    chk("conflict_code", 32'(err_code), 32'd2);
    chk("conflict_count", 32'(err_count), 32'd1);
    step(3'b110, LG, 1'b1);
    chk("enc2_code", 32'(err_code), 32'd1);
    chk("enc2_count", 32'(err_count), 32'd1);

    // Short green on EW (3 cycles then yellow)
    step(LR, LG, 1'b1);
    step(LR, LY, 1'b0);
    chk("short_green_code", 32'(err_code), DW ? 32'd4 : 32'd0);
    step(LR, LY, 1'b0);
    step(LR, LR, 1'b1);

    // Long green on NS: flagged on the 11th cycle only
    hold(LG, LR, 10);
    chk("long_pre_pulse", 32'(err_pulse), 32'd0);
    step(LG, LR, 1'b0);
    chk("long_pulse", 32'(err_pulse), DW ? 32'd1 : 32'd0);
    chk("long_code", 32'(err_code), DW ? 32'd5 : 32'd0);
    step(LG, LR, 1'b0);
    chk("long_after_pulse", 32'(err_pulse), 32'd0);
    hold(LY, LR, 2);
    step(LR, LR, 1'b1);

    // Green straight to red, then clear coinciding with a new conflict
    step(LG, LR, 1'b0);
    hold(LG, LR, 4);
    step(LR, LR, 1'b0);
    chk("g2r_code", 32'(err_code), 32'd3);
    step(LG, LG, 1'b1);
    chk("clr_conf_sticky", 32'(err_sticky), 32'd1);
    chk("clr_conf_code", 32'(err_code), 32'd2);
    chk("clr_conf_count", 32'(err_count), 32'd1);
    step(LG, LR, 1'b1);
    step(LG, LR, 1'b1);

    // Asynchronous reset mid-green, release into NS yellow
    rst = 1'b0;
    #2;
    model_reset();
    check_all();
    step(LG, LR, 1'b0);
    rst = 1'b1;
    step(LY, LR, 1'b0);
    chk("post_rst_pulse", 32'(err_pulse), 32'd0);
    chk("post_rst_phase", 32'(ns_phase), 32'd1);
    step(LY, LR, 1'b0);
    step(LR, LR, 1'b0);
    chk("post_rst_y2r_pulse", 32'(err_pulse), 32'd0);

    // Randomized controller traffic with glitches
    for (int c = 0; c < 15; c++) begin
      gd = int'($urandom_range(3, 12));
      yd = int'($urandom_range(1, 3));
      for (int s = 0; s < gd + yd; s++) rstep((s < gd) ? LG : LY, LR);
      gd = int'($urandom_range(3, 12));
      yd = int'($urandom_range(1, 3));
      for (int s = 0; s < gd + yd; s++) rstep(LR, (s < gd) ? LG : LY);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
